// File: rtl/ddr_arbiter.sv
// Round-robin two-port front end for ddr_ctrl. Each granted 256-bit block access is
// issued as two 128-bit half accesses (low half first), each completed by ram_rdy.
module ddr_arbiter #(
    parameter int HALF_BIT = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p0_req,
    input  logic [29:0]  p0_addr,
    output logic         p0_ack,
    input  logic         p1_req,
    input  logic         p1_write,
    input  logic [29:0]  p1_addr,
    input  logic [255:0] p1_wdata,
    output logic         p1_ack,
    output logic [255:0] rdata,
    output logic         ram_en,
    output logic         ram_write,
    output logic [29:0]  ram_addr,
    output logic [255:0] data_to_ram,
    input  logic         ram_rdy,
    input  logic [255:0] block_out,
    output logic         busy,
    output logic         ddr_err
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 13) ? $clog2(TIMEOUT + 1) : 13;

    typedef enum logic [2:0] {IDLE, LO, LO_WAIT, HI, HI_WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           grant_q, grant_d;
    logic           ram_write_q, ram_write_d;
    logic [29:0]    ram_addr_q, ram_addr_d;
    logic [255:0]   data_q, data_d;
    logic [127:0]   stage_q, stage_d;
    logic [255:0]   rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           err_q, err_d;
    logic           pick_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_addr_q   <= '0;
            data_q       <= '0;
            stage_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ram_write_q  <= ram_write_d;
            ram_addr_q   <= ram_addr_d;
            data_q       <= data_d;
            stage_q      <= stage_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ram_write_d  = ram_write_q;
        ram_addr_d   = ram_addr_q;
        data_d       = data_q;
        stage_d      = stage_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        pick_p1      = 1'b0;
        cnt_inc      = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                // On a tie the port that lost the previous grant wins.
                pick_p1 = p1_req && (!p0_req || !last_grant_q);
                if (p0_req || p1_req) begin
                    grant_d              = pick_p1;
                    ram_addr_d           = pick_p1 ? p1_addr : p0_addr;
                    ram_addr_d[HALF_BIT] = 1'b0;
                    ram_write_d          = pick_p1 && p1_write;
                    data_d               = pick_p1 ? p1_wdata : '0;
                    cnt_d                = '0;
                    state_d              = LO;
                end
            end
            LO: state_d = LO_WAIT;
            LO_WAIT: begin
                cnt_d = cnt_inc;
                err_d = err_q || (cnt_inc == CW'(TIMEOUT));
                if (ram_rdy) begin
                    if (!ram_write_q) stage_d = block_out[127:0];
                    ram_addr_d[HALF_BIT] = 1'b1;
                    cnt_d                = '0;
                    state_d              = HI;
                end
            end
            HI: state_d = HI_WAIT;
            HI_WAIT: begin
                cnt_d = cnt_inc;
                err_d = err_q || (cnt_inc == CW'(TIMEOUT));
                // rdata loads on the edge into DONE so it is valid while the ack is high.
                if (ram_rdy) begin
                    if (!ram_write_q) rdata_d = {block_out[255:128], stage_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_ack      = (state_q == DONE) && !grant_q;
    assign p1_ack      = (state_q == DONE) && grant_q;
    assign ram_en      = (state_q == LO) || (state_q == LO_WAIT) ||
                         (state_q == HI) || (state_q == HI_WAIT);
    assign busy        = (state_q != IDLE);
    assign ram_write   = ram_write_q;
    assign ram_addr    = ram_addr_q;
    assign data_to_ram = data_q;
    assign rdata       = rdata_q;
    assign ddr_err     = err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: a behavioural ddr_ctrl stand-in plus a
// round-robin/memory reference model, driven by directed and randomized requests.
module tb_ddr_arbiter;

    localparam int HALF_BIT   = 4;
    localparam int TIMEOUT    = 4096;
    localparam int WAIT_LIMIT = 3 * TIMEOUT;

    logic         clk = 1'b0;
    logic         rst;
    logic         p0_req, p1_req, p1_write;
    logic [29:0]  p0_addr, p1_addr;
    logic [255:0] p1_wdata;
    logic         p0_ack, p1_ack;
    logic [255:0] rdata;
    logic         ram_en, ram_write;
    logic [29:0]  ram_addr;
    logic [255:0] data_to_ram;
    logic         ram_rdy;
    logic [255:0] block_out;
    logic         busy, ddr_err;

    int           checks = 0;
    int           errors = 0;

    // ddr_ctrl stand-in: ram_rdy rises rdy_delay cycles after each address change.
    int           rdy_delay = 1;
    bit           stall = 1'b0;
    int           ddr_cnt = 0;
    logic         mon_prev_en = 1'b0;
    logic [29:0]  mon_prev_addr = '0;
    logic [29:0]  addr_log[$];

    logic [255:0] exp_rdata = '0;
    bit           model_last = 1'b1;
    logic [255:0] wd;

    ddr_arbiter #(.HALF_BIT(HALF_BIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rdata(rdata), .ram_en(ram_en), .ram_write(ram_write),
        .ram_addr(ram_addr), .data_to_ram(data_to_ram),
        .ram_rdy(ram_rdy), .block_out(block_out),
        .busy(busy), .ddr_err(ddr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lo_word(input logic [29:0] a);
        logic [31:0] x;
        x = {2'b00, a} * 32'h9E3779B1;
        return {x, x ^ 32'hDEADBEEF, x + 32'h01234567, ~x};
    endfunction

    function automatic logic [127:0] hi_word(input logic [29:0] a);
        logic [31:0] x;
        x = {2'b00, a} * 32'h85EBCA6B + 32'h5A5A5A5A;
        return {~x, x + 32'h07654321, x, x ^ 32'h0F0F0F0F};
    endfunction

    function automatic logic [29:0] half_bit_mask();
        return 30'd1 << HALF_BIT;
    endfunction

    // Expected block: low half from the cleared-bit address, high half from the set-bit address.
    function automatic logic [255:0] ref_block(input logic [29:0] addr);
        logic [29:0] base;
        base = addr & ~half_bit_mask();
        return {hi_word(base | half_bit_mask()), lo_word(base)};
    endfunction

    assign block_out = {hi_word(ram_addr), lo_word(ram_addr)};
    assign ram_rdy   = ram_en && !stall && (ddr_cnt >= rdy_delay);

    always @(negedge clk) begin
        if (!ram_en || !mon_prev_en || ram_addr != mon_prev_addr) ddr_cnt = 0;
        else ddr_cnt = ddr_cnt + 1;
        if (ram_en && (!mon_prev_en || ram_addr != mon_prev_addr)) addr_log.push_back(ram_addr);
        mon_prev_en   = ram_en;
        mon_prev_addr = ram_addr;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [29:0] addr, input bit wr,
                                 input logic [255:0] wdata);
        if (port == 0) begin
            p0_addr = addr;
            p0_req  = 1'b1;
        end else begin
            p1_addr  = addr;
            p1_write = wr;
            p1_wdata = wdata;
            p1_req   = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_p0_ack"}, p0_ack, 0);
        checkOutput({tag, "_p1_ack"}, p1_ack, 0);
        checkOutput({tag, "_ram_en"}, ram_en, 0);
        checkOutput({tag, "_ram_write"}, ram_write, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ddr_err"}, ddr_err, 0);
        checkOutput({tag, "_ram_addr"}, ram_addr, 0);
        checkOutput({tag, "_data_to_ram"}, data_to_ram, 0);
        checkOutput({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic waitAck(input bit exp_w, input logic [255:0] exp_wd, output int cyc,
                           output logic [1:0] acks, output bit bad);
        cyc  = 0;
        bad  = 1'b0;
        acks = 2'b00;
        while (cyc < WAIT_LIMIT && acks == 2'b00) begin
            @(negedge clk);
            cyc++;
            if (ram_en && (ram_write !== exp_w || (exp_w && data_to_ram !== exp_wd))) bad = 1'b1;
            acks = {p1_ack, p0_ack};
        end
    endtask

    // Waits for the ack of the predicted winner and checks the whole block transfer.
    task automatic checkTxn(input string tag, input int port, input logic [29:0] addr,
                            input bit wr, input logic [255:0] wdata, input int exp_lat,
                            input bit clear_log);
        int          cyc;
        logic [1:0]  acks;
        bit          bad;
        logic [29:0] base;
        base = addr & ~half_bit_mask();
        if (clear_log) addr_log.delete();
        waitAck(wr, wdata, cyc, acks, bad);
        checkOutput({tag, "_ack"}, 256'(acks), 256'(2'b01 << port));
        if (exp_lat >= 0) checkOutput({tag, "_latency"}, 256'(cyc), 256'(exp_lat));
        checkOutput({tag, "_wr_drive"}, 256'(bad), 0);
        checkOutput({tag, "_halves"}, 256'(addr_log.size()), 2);
        if (addr_log.size() >= 2) begin
            checkOutput({tag, "_lo_addr"}, addr_log[0], base);
            checkOutput({tag, "_hi_addr"}, addr_log[1], base | half_bit_mask());
        end
        if (!wr) exp_rdata = ref_block(addr);
        checkOutput({tag, "_rdata"}, rdata, exp_rdata);
        checkOutput({tag, "_done_en"}, {busy, ram_en}, 2'b10);
        model_last = (port != 0);
        if (port == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    initial begin
        #(2000000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        p0_req   = 1'b0;
        p1_req   = 1'b0;
        p1_write = 1'b0;
        p0_addr  = '0;
        p1_addr  = '0;
        p1_wdata = '0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        @(negedge clk);

        // Port 0 read; ready arrives two cycles late in each wait state.
        rdy_delay = 3;
        applyStimulus(0, 30'h100, 1'b0, '0);
        checkTxn("p0_read", 0, 30'h100, 1'b0, '0, 9, 1'b1);
        @(negedge clk);
        checkOutput("p0_ack_once", {p1_ack, p0_ack}, 0);

        // Port 1 write at minimum latency; rdata must not move.
        rdy_delay = 1;
        wd = {{32{4'hA}}, {32{4'h5}}};
        applyStimulus(1, 30'h2000, 1'b1, wd);
        checkTxn("p1_write", 1, 30'h2000, 1'b1, wd, 5, 1'b1);
        @(negedge clk);
        checkOutput("p1_ack_once", {p1_ack, p0_ack}, 0);

        // Both ports requesting continuously: grants alternate starting with port 0.
        rdy_delay = 2;
        applyStimulus(0, 30'h0ABC0, 1'b0, '0);
        applyStimulus(1, 30'h1F3C4, 1'b0, '0);
        for (int t = 0; t < 6; t++) begin
            checkTxn($sformatf("rr%0d", t), t % 2, (t % 2 == 1) ? p1_addr : p0_addr,
                     1'b0, '0, -1, 1'b1);
            if (t == 5) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            @(negedge clk);
            checkOutput("rr_ack_pulse", {p1_ack, p0_ack}, 0);
            if (t < 5)
                applyStimulus(t % 2, (t % 2 == 1) ? p1_addr + 30'h40 : p0_addr + 30'h40,
                              1'b0, '0);
        end

        // ram_rdy stuck low in LO_WAIT: error flag rises after exactly TIMEOUT wait cycles.
        stall     = 1'b1;
        rdy_delay = 1;
        applyStimulus(0, 30'h3FF0, 1'b0, '0);
        addr_log.delete();
        @(negedge clk);
        checkOutput("to_lo_en", ram_en, 1);
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("to_err_before", ddr_err, 0);
        @(negedge clk);
        checkOutput("to_err_at", ddr_err, 1);
        repeat (4) @(negedge clk);
        checkOutput("to_still_waiting", {busy, ram_en, p0_ack}, 3'b110);
        stall = 1'b0;
        checkTxn("timeout", 0, 30'h3FF0, 1'b0, '0, -1, 1'b0);
        @(negedge clk);
        checkOutput("to_err_sticky", ddr_err, 1);

        // Randomized mix of requests, directions and ready delays.
        for (int it = 0; it < 24; it++) begin
            int          win;
            logic [29:0] a;
            bit          wr;
            rdy_delay = $urandom_range(1, 4);
            if (!p0_req && ($urandom_range(0, 1) == 1))
                applyStimulus(0, 30'($urandom), 1'b0, '0);
            if (!p1_req && ($urandom_range(0, 1) == 1)) begin
                for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
                applyStimulus(1, 30'($urandom), 1'($urandom_range(0, 1)), wd);
            end
            if (!p0_req && !p1_req) applyStimulus(0, 30'($urandom), 1'b0, '0);
            win = (p0_req && p1_req) ? (model_last ? 0 : 1) : (p1_req ? 1 : 0);
            a   = (win == 1) ? p1_addr : p0_addr;
            wr  = (win == 1) ? p1_write : 1'b0;
            checkTxn("rand", win, a, wr, p1_wdata, -1, 1'b1);
            @(negedge clk);
            checkOutput("rand_ack_pulse", {p1_ack, p0_ack}, 0);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in HI_WAIT: outputs clear at once and no ack follows.
        rdy_delay = 10;
        applyStimulus(0, 30'h7770, 1'b0, '0);
        repeat (14) @(negedge clk);
        checkOutput("pre_rst_en", ram_en, 1);
        #1 rst = 1'b0;
        #1 checkResetValues("async_rst");
        p0_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_ack", {p1_ack, p0_ack}, 0);
        end
        rst        = 1'b1;
        model_last = 1'b1;
        exp_rdata  = '0;
        @(negedge clk);

        // After reset port 0 wins the first tie and reads complete normally.
        rdy_delay = 1;
        applyStimulus(0, 30'h5550, 1'b0, '0);
        applyStimulus(1, 30'h6660, 1'b0, '0);
        checkTxn("post_rst_p0", 0, 30'h5550, 1'b0, '0, 5, 1'b1);
        @(negedge clk);
        checkTxn("post_rst_p1", 1, 30'h6660, 1'b0, '0, 5, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_err", ddr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
